// File: rtl/cnn_layer_seq_if.sv
// Bundle of control, handshake and stage-enable signals between the CNN
// layer sequencer and its environment (AXI input side and datapath blocks).
//
// Handshake rule for both streams: a beat transfers on a rising clk edge
// where valid and ready are both high. The source holds valid and its beat
// until that edge, and ready never depends combinationally on valid.
//
// dbg_state exposes the sequencer state code so that checkers can observe it.
interface cnn_layer_seq_if #(
    parameter int MAX_FILTERS = 32,
    parameter int ELEM_W      = 6,
    parameter int FW          = $clog2(MAX_FILTERS + 1)
);
    // layer control
    logic                   start_i;
    logic                   abort_i;
    logic [2:0]             op_mode_i;
    logic [FW-1:0]          num_filters_i;
    logic [ELEM_W-1:0]      filter_elems_i;

    // weight and image streams
    logic                   w_valid_i;
    logic                   w_ready_o;
    logic                   img_valid_i;
    logic                   img_ready_o;

    // datapath stage finish handshakes
    logic                   pu_finish_i;
    logic                   conv_finish_i;
    logic                   pool_finish_i;
    logic                   fc_finish_i;

    // sequencer outputs
    logic [MAX_FILTERS-1:0] weight_en_o;
    logic                   pu_en_o;
    logic                   conv_en_o;
    logic                   pool_en_o;
    logic                   fc_en_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;
    logic [2:0]             dbg_state;

    // environment side: drives control, stream valids and finishes
    modport master (
        output start_i, abort_i, op_mode_i, num_filters_i, filter_elems_i,
        output w_valid_i, img_valid_i,
        output pu_finish_i, conv_finish_i, pool_finish_i, fc_finish_i,
        input  w_ready_o, img_ready_o, weight_en_o,
        input  pu_en_o, conv_en_o, pool_en_o, fc_en_o,
        input  busy_o, done_o, err_o, dbg_state
    );

    // sequencer side
    modport slave (
        input  start_i, abort_i, op_mode_i, num_filters_i, filter_elems_i,
        input  w_valid_i, img_valid_i,
        input  pu_finish_i, conv_finish_i, pool_finish_i, fc_finish_i,
        output w_ready_o, img_ready_o, weight_en_o,
        output pu_en_o, conv_en_o, pool_en_o, fc_en_o,
        output busy_o, done_o, err_o, dbg_state
    );
endinterface

// File: rtl/cnn_layer_seq.sv
// CNN layer sequencer. Loads a configurable number of filters into one-hot
// selected weight buffers, pre-buffers a fixed number of image beats, then
// walks conv, optional pooling and optional FC stages driven by the finish
// handshakes of the datapath blocks. All outputs except weight_en_o are
// registered decodes of the state being entered, so they line up exactly
// with the state register.
module cnn_layer_seq #(
    parameter int MAX_FILTERS    = 32,
    parameter int ELEM_W         = 6,
    parameter int ELEMS_PER_BEAT = 2,
    parameter int IMG_PRELOAD    = 68,
    parameter int FW             = $clog2(MAX_FILTERS + 1)
) (
    input logic           clk,
    input logic           nrst,
    cnn_layer_seq_if.slave bus
);

    // element counter is one bit wider than the element count so the sum of
    // a partial count and a full beat can never wrap
    localparam int NW = ELEM_W + 1;
    localparam int PW = $clog2(IMG_PRELOAD + 1);

    localparam logic [2:0] MODE_CONV      = 3'b001;
    localparam logic [2:0] MODE_CONV_POOL = 3'b010;
    localparam logic [2:0] MODE_FC        = 3'b011;
    localparam logic [2:0] MODE_FULL      = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_PRELOAD = 3'd2,
        S_CONV    = 3'd3,
        S_POOL    = 3'd4,
        S_FC      = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            state, state_nxt;

    // configuration captured at start
    logic [2:0]        mode_r;
    logic [FW-1:0]     nf_r;
    logic [ELEM_W-1:0] ne_r;
    logic              latch_cfg;

    // progress counters
    logic [FW-1:0]     f_cnt, f_nxt;
    logic [NW-1:0]     n_cnt, n_nxt;
    logic [PW-1:0]     img_cnt, img_nxt;
    logic              pu_done, pu_done_nxt;
    logic              err_nxt;

    // registered outputs
    logic              w_ready_r;
    logic              img_ready_r;
    logic              pu_en_r;
    logic              conv_en_r;
    logic              pool_en_r;
    logic              fc_en_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    // weight beat arithmetic
    logic [NW-1:0]     rem_elems;
    logic [NW-1:0]     beat_inc;
    logic [NW-1:0]     n_sum;
    logic              filter_full;
    logic              last_filter;

    // configuration check on the live inputs
    logic              mode_known;
    logic              conv_mode;
    logic              cfg_bad;

    // a beat carries up to ELEMS_PER_BEAT elements; the last beat of a filter
    // only carries what is left, so odd counts waste its tail slot
    always_comb begin
        rem_elems   = {1'b0, ne_r} - n_cnt;
        beat_inc    = (rem_elems > NW'(ELEMS_PER_BEAT)) ? NW'(ELEMS_PER_BEAT) : rem_elems;
        n_sum       = n_cnt + beat_inc;
        filter_full = (n_sum == {1'b0, ne_r});
        last_filter = ((f_cnt + FW'(1)) == nf_r);
    end

    // reject unknown modes, empty or oversized filter sets, and empty filters
    // in any mode that loads weights
    always_comb begin
        mode_known = (bus.op_mode_i == MODE_CONV)      ||
                     (bus.op_mode_i == MODE_CONV_POOL) ||
                     (bus.op_mode_i == MODE_FC)        ||
                     (bus.op_mode_i == MODE_FULL);
        conv_mode  = (bus.op_mode_i != MODE_FC);
        cfg_bad    = !mode_known ||
                     (bus.num_filters_i == '0) ||
                     (bus.num_filters_i > FW'(MAX_FILTERS)) ||
                     (conv_mode && (bus.filter_elems_i == '0));
    end

    // next state and counter updates; abort overrides everything, including
    // a start in the same cycle
    always_comb begin
        state_nxt   = state;
        f_nxt       = f_cnt;
        n_nxt       = n_cnt;
        img_nxt     = img_cnt;
        pu_done_nxt = pu_done;
        err_nxt     = 1'b0;
        latch_cfg   = 1'b0;

        if (bus.abort_i) begin
            state_nxt   = S_IDLE;
            f_nxt       = '0;
            n_nxt       = '0;
            img_nxt     = '0;
            pu_done_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        if (cfg_bad) begin
                            err_nxt = 1'b1;
                        end else begin
                            latch_cfg   = 1'b1;
                            f_nxt       = '0;
                            n_nxt       = '0;
                            img_nxt     = '0;
                            pu_done_nxt = 1'b0;
                            state_nxt   = (bus.op_mode_i == MODE_FC) ? S_FC : S_LOAD_W;
                        end
                    end
                end

                S_LOAD_W: begin
                    if (bus.w_valid_i && w_ready_r) begin
                        if (filter_full) begin
                            n_nxt = '0;
                            f_nxt = f_cnt + FW'(1);
                            if (last_filter) begin
                                state_nxt = S_PRELOAD;
                            end
                        end else begin
                            n_nxt = n_sum;
                        end
                    end
                end

                S_PRELOAD: begin
                    if (bus.img_valid_i && img_ready_r) begin
                        if (img_cnt == PW'(IMG_PRELOAD - 1)) begin
                            img_nxt   = '0;
                            state_nxt = S_CONV;
                        end else begin
                            img_nxt = img_cnt + PW'(1);
                        end
                    end
                end

                S_CONV: begin
                    // both finishes may land together; each is honoured
                    if (bus.pu_finish_i) begin
                        pu_done_nxt = 1'b1;
                    end
                    if (bus.conv_finish_i) begin
                        state_nxt = (mode_r == MODE_CONV) ? S_DONE : S_POOL;
                    end
                end

                S_POOL: begin
                    if (bus.pool_finish_i) begin
                        state_nxt = (mode_r == MODE_FULL) ? S_FC : S_DONE;
                    end
                end

                S_FC: begin
                    if (bus.fc_finish_i) begin
                        state_nxt = S_DONE;
                    end
                end

                S_DONE: begin
                    f_nxt       = '0;
                    n_nxt       = '0;
                    img_nxt     = '0;
                    pu_done_nxt = 1'b0;
                    state_nxt   = S_IDLE;
                end

                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // state, counters, captured configuration and outputs decoded from the
    // state being entered
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_IDLE;
            mode_r      <= '0;
            nf_r        <= '0;
            ne_r        <= '0;
            f_cnt       <= '0;
            n_cnt       <= '0;
            img_cnt     <= '0;
            pu_done     <= 1'b0;
            w_ready_r   <= 1'b0;
            img_ready_r <= 1'b0;
            pu_en_r     <= 1'b0;
            conv_en_r   <= 1'b0;
            pool_en_r   <= 1'b0;
            fc_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state   <= state_nxt;
            f_cnt   <= f_nxt;
            n_cnt   <= n_nxt;
            img_cnt <= img_nxt;
            pu_done <= pu_done_nxt;
            if (latch_cfg) begin
                mode_r <= bus.op_mode_i;
                nf_r   <= bus.num_filters_i;
                ne_r   <= bus.filter_elems_i;
            end
            w_ready_r   <= (state_nxt == S_LOAD_W);
            img_ready_r <= (state_nxt == S_PRELOAD) || (state_nxt == S_CONV);
            pu_en_r     <= (state_nxt == S_PRELOAD) ||
                           ((state_nxt == S_CONV) && !pu_done_nxt);
            conv_en_r   <= (state_nxt == S_CONV);
            pool_en_r   <= (state_nxt == S_POOL);
            fc_en_r     <= (state_nxt == S_FC);
            busy_r      <= (state_nxt != S_IDLE);
            done_r      <= (state_nxt == S_DONE);
            err_r       <= err_nxt;
        end
    end

    // weight buffer select follows the live valid so a stalled beat writes
    // nothing; it is gated by ready so only LOAD_W can write
    assign bus.weight_en_o = (MAX_FILTERS'(1) << f_cnt) &
                             {MAX_FILTERS{bus.w_valid_i & w_ready_r}};

    assign bus.w_ready_o   = w_ready_r;
    assign bus.img_ready_o = img_ready_r;
    assign bus.pu_en_o     = pu_en_r;
    assign bus.conv_en_o   = conv_en_r;
    assign bus.pool_en_o   = pool_en_r;
    assign bus.fc_en_o     = fc_en_r;
    assign bus.busy_o      = busy_r;
    assign bus.done_o      = done_r;
    assign bus.err_o       = err_r;
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed bench for the CNN layer sequencer. A layer-level model predicts
// every output each cycle from beat totals and stage names; directed
// sequences add hand-computed literal expectations on top.
module tb_cnn_layer_seq;

    localparam int MAXF = 32;
    localparam int EW   = 6;
    localparam int EPB  = 2;
    localparam int PRE  = 68;
    localparam int FW   = $clog2(MAXF + 1);

    localparam int ST_IDLE = 0;
    localparam int ST_LW   = 1;
    localparam int ST_PRE  = 2;
    localparam int ST_CONV = 3;
    localparam int ST_POOL = 4;
    localparam int ST_FC   = 5;
    localparam int ST_DONE = 6;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    cnn_layer_seq_if #(.MAX_FILTERS(MAXF), .ELEM_W(EW), .FW(FW)) bus ();

    cnn_layer_seq #(
        .MAX_FILTERS(MAXF), .ELEM_W(EW), .ELEMS_PER_BEAT(EPB),
        .IMG_PRELOAD(PRE), .FW(FW)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    // ---------------- layer-level model ----------------
    int  m_stage, m_mode, m_nf, m_ne, m_beats, m_img;
    bit  m_pu_seen, m_err;

    function automatic bit cfg_ok(input int mode, input int nf, input int ne);
        bit conv;
        conv = (mode == 1) || (mode == 2) || (mode == 6);
        if (!conv && mode != 3) return 1'b0;
        if (nf < 1 || nf > MAXF) return 1'b0;
        if (conv && ne == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int beats_per_filter(input int ne);
        return (ne + EPB - 1) / EPB;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_stage <= ST_IDLE; m_mode <= 0; m_nf <= 0; m_ne <= 0;
            m_beats <= 0; m_img <= 0; m_pu_seen <= 1'b0; m_err <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (bus.abort_i) begin
                m_stage <= ST_IDLE; m_beats <= 0; m_img <= 0; m_pu_seen <= 1'b0;
            end else begin
                case (m_stage)
                    ST_IDLE: if (bus.start_i) begin
                        if (!cfg_ok(int'(bus.op_mode_i), int'(bus.num_filters_i), int'(bus.filter_elems_i))) begin
                            m_err <= 1'b1;
                        end else begin
                            m_mode <= int'(bus.op_mode_i);
                            m_nf   <= int'(bus.num_filters_i);
                            m_ne   <= int'(bus.filter_elems_i);
                            m_beats <= 0; m_img <= 0; m_pu_seen <= 1'b0;
                            m_stage <= (bus.op_mode_i == 3'b011) ? ST_FC : ST_LW;
                        end
                    end
                    ST_LW: if (bus.w_valid_i) begin
                        m_beats <= m_beats + 1;
                        if (m_beats + 1 == m_nf * beats_per_filter(m_ne)) m_stage <= ST_PRE;
                    end
                    ST_PRE: if (bus.img_valid_i) begin
                        m_img <= m_img + 1;
                        if (m_img + 1 == PRE) m_stage <= ST_CONV;
                    end
                    ST_CONV: begin
                        if (bus.pu_finish_i) m_pu_seen <= 1'b1;
                        if (bus.conv_finish_i) m_stage <= (m_mode == 1) ? ST_DONE : ST_POOL;
                    end
                    ST_POOL: if (bus.pool_finish_i) m_stage <= (m_mode == 6) ? ST_FC : ST_DONE;
                    ST_FC:   if (bus.fc_finish_i) m_stage <= ST_DONE;
                    default: begin
                        m_stage <= ST_IDLE; m_beats <= 0; m_img <= 0; m_pu_seen <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic             obs_w_ready, obs_img_ready, obs_pu_en, obs_conv, obs_pool, obs_fc;
    logic             obs_busy, obs_done, obs_err;
    logic [8:0]       obs_vec, exp_vec;
    logic [MAXF-1:0]  obs_wen, exp_wen;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // one cycle: sample and compare on the falling edge, then advance past
    // the next rising edge so inputs can be changed safely
    task automatic step();
        @(negedge clk);
        obs_w_ready   = bus.w_ready_o;
        obs_img_ready = bus.img_ready_o;
        obs_pu_en     = bus.pu_en_o;
        obs_conv      = bus.conv_en_o;
        obs_pool      = bus.pool_en_o;
        obs_fc        = bus.fc_en_o;
        obs_busy      = bus.busy_o;
        obs_done      = bus.done_o;
        obs_err       = bus.err_o;
        obs_wen       = bus.weight_en_o;
        obs_vec = {obs_w_ready, obs_img_ready, obs_pu_en, obs_conv, obs_pool,
                   obs_fc, obs_busy, obs_done, obs_err};
        exp_vec = {m_stage == ST_LW,
                   (m_stage == ST_PRE) || (m_stage == ST_CONV),
                   (m_stage == ST_PRE) || ((m_stage == ST_CONV) && !m_pu_seen),
                   m_stage == ST_CONV, m_stage == ST_POOL, m_stage == ST_FC,
                   m_stage != ST_IDLE, m_stage == ST_DONE, m_err};
        if (m_stage == ST_LW && bus.w_valid_i)
            exp_wen = MAXF'(1) << (m_beats / beats_per_filter(m_ne));
        else
            exp_wen = '0;
        if (chk_en) begin
            check("model_outputs", 64'(obs_vec), 64'(exp_vec));
            check("model_weight_en", 64'(obs_wen), 64'(exp_wen));
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_layer(input logic [2:0] mode, input int nf, input int ne);
        bus.op_mode_i      = mode;
        bus.num_filters_i  = FW'(nf);
        bus.filter_elems_i = EW'(ne);
        bus.start_i        = 1'b1;
        step();
        bus.start_i        = 1'b0;
    endtask

    task automatic load_weights(input bit toggle, output int beats,
                                output logic [MAXF-1:0] en_first,
                                output logic [MAXF-1:0] en_sixth, output int en_bad);
        int cyc;
        bit ended;
        beats = 0; en_bad = 0; en_first = '0; en_sixth = '0; ended = 1'b0;
        for (cyc = 0; cyc < 100 && !ended; cyc++) begin
            bus.w_valid_i = toggle ? (cyc % 2 == 0) : 1'b1;
            step();
            if (!obs_w_ready) begin
                ended = 1'b1;
            end else if (bus.w_valid_i) begin
                beats++;
                if (beats == 1) en_first = obs_wen;
                if (beats == 6) en_sixth = obs_wen;
            end else if (obs_wen != '0) begin
                en_bad++;
            end
        end
        bus.w_valid_i = 1'b0;
        if (!ended) check("load_timeout", 64'(obs_w_ready), 64'(0));
    endtask

    task automatic run_preload(input bit toggle, output int imgs);
        int cyc;
        bit ended;
        imgs = 0; ended = 1'b0;
        for (cyc = 0; cyc < 300 && !ended; cyc++) begin
            bus.img_valid_i = toggle ? (cyc % 2 == 1) : 1'b1;
            step();
            if (obs_conv) ended = 1'b1;
            else if (bus.img_valid_i && obs_img_ready) imgs++;
        end
        bus.img_valid_i = 1'b0;
        if (!ended) check("preload_timeout", 64'(obs_conv), 64'(1));
    endtask

    // runs a few cycles and reports how many carried done_o
    task automatic count_done(output int dones);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (obs_done) dones++;
        end
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        int               beats, en_bad, imgs, dones;
        logic [MAXF-1:0]  en_first, en_sixth;

        bus.start_i = 0; bus.abort_i = 0; bus.op_mode_i = 0;
        bus.num_filters_i = 0; bus.filter_elems_i = 0;
        bus.w_valid_i = 0; bus.img_valid_i = 0;
        bus.pu_finish_i = 0; bus.conv_finish_i = 0;
        bus.pool_finish_i = 0; bus.fc_finish_i = 0;

        chk_en = 1'b1;
        step(); step();
        check("reset_outputs", 64'(obs_vec), 64'(0));
        check("reset_weight_en", 64'(obs_wen), 64'(0));
        nrst = 1'b1;
        step();

        // conv only, 2 filters x 9 elements; config inputs change mid-run
        start_layer(3'b001, 2, 9);
        bus.op_mode_i = 3'b100; bus.num_filters_i = FW'(5);
        load_weights(1'b0, beats, en_first, en_sixth, en_bad);
        check("conv_beats", 64'(beats), 64'd10);
        check("conv_en_first", 64'(en_first), 64'h1);
        check("conv_en_sixth", 64'(en_sixth), 64'h2);
        run_preload(1'b0, imgs);
        check("conv_img_beats", 64'(imgs), 64'd68);
        check("conv_stage_en", 64'({obs_conv, obs_pool, obs_fc, obs_pu_en}), 64'b1001);
        bus.conv_finish_i = 1'b1; step(); bus.conv_finish_i = 1'b0;
        count_done(dones);
        check("conv_done_pulses", 64'(dones), 64'd1);
        check("conv_idle_after", 64'(obs_busy), 64'd0);

        // backpressure on the weight stream, then abort during preload
        start_layer(3'b001, 2, 9);
        load_weights(1'b1, beats, en_first, en_sixth, en_bad);
        check("bp_beats", 64'(beats), 64'd10);
        check("bp_en_idle_cycles", 64'(en_bad), 64'd0);
        check("bp_en_sixth", 64'(en_sixth), 64'h2);
        bus.img_valid_i = 1'b1; step(); step();
        bus.abort_i = 1'b1; step(); bus.abort_i = 1'b0; bus.img_valid_i = 1'b0;
        step();
        check("bp_abort_busy", 64'({obs_busy, obs_img_ready, obs_pu_en}), 64'd0);

        // full flow conv+pool+fc, 1 filter x 3 elements (two beats)
        start_layer(3'b110, 1, 3);
        load_weights(1'b0, beats, en_first, en_sixth, en_bad);
        check("full_beats", 64'(beats), 64'd2);
        run_preload(1'b1, imgs);
        check("full_img_beats", 64'(imgs), 64'd68);
        check("full_conv_stage", 64'({obs_conv, obs_pool, obs_fc}), 64'b100);
        bus.pu_finish_i = 1'b1; bus.conv_finish_i = 1'b1; step();
        bus.pu_finish_i = 1'b0; bus.conv_finish_i = 1'b0;
        step();
        check("full_pool_stage", 64'({obs_conv, obs_pool, obs_fc, obs_pu_en}), 64'b0100);
        // stray finishes and a start while busy must be ignored
        bus.fc_finish_i = 1'b1; bus.conv_finish_i = 1'b1; bus.start_i = 1'b1; step();
        bus.fc_finish_i = 1'b0; bus.conv_finish_i = 1'b0; bus.start_i = 1'b0;
        step();
        check("full_pool_hold", 64'({obs_conv, obs_pool, obs_fc}), 64'b010);
        bus.pool_finish_i = 1'b1; step(); bus.pool_finish_i = 1'b0;
        step();
        check("full_fc_stage", 64'({obs_conv, obs_pool, obs_fc}), 64'b001);
        bus.fc_finish_i = 1'b1; step(); bus.fc_finish_i = 1'b0;
        count_done(dones);
        check("full_done_pulses", 64'(dones), 64'd1);

        // FC only: straight to FC, no weight loading
        start_layer(3'b011, 1, 0);
        step();
        check("fc_only_stage", 64'({obs_fc, obs_w_ready, obs_busy}), 64'b101);
        bus.fc_finish_i = 1'b1; step(); bus.fc_finish_i = 1'b0;
        count_done(dones);
        check("fc_only_done", 64'(dones), 64'd1);

        // configuration errors
        start_layer(3'b100, 1, 1); step();
        check("err_mode100", 64'({obs_err, obs_busy}), 64'b10);
        step();
        check("err_one_cycle", 64'(obs_err), 64'd0);
        start_layer(3'b001, 0, 9); step();
        check("err_nf_zero", 64'({obs_err, obs_busy}), 64'b10);
        start_layer(3'b001, 33, 9); step();
        check("err_nf_big", 64'({obs_err, obs_busy}), 64'b10);
        start_layer(3'b010, 1, 0); step();
        check("err_elems_zero", 64'({obs_err, obs_busy}), 64'b10);
        bus.abort_i = 1'b1;
        start_layer(3'b100, 1, 1);
        bus.abort_i = 1'b0;
        step();
        check("abort_beats_start", 64'({obs_err, obs_busy}), 64'b00);

        // abort mid-load, restart from filter 0, sticky PU clear in conv
        start_layer(3'b001, 2, 9);
        bus.w_valid_i = 1'b1;
        step(); step(); step();
        bus.abort_i = 1'b1; step(); bus.abort_i = 1'b0;
        step();
        check("abort_idle", 64'({obs_busy, obs_w_ready}), 64'b00);
        check("abort_weight_en", 64'(obs_wen), 64'd0);
        bus.w_valid_i = 1'b0;
        start_layer(3'b001, 2, 9);
        load_weights(1'b0, beats, en_first, en_sixth, en_bad);
        check("restart_en_first", 64'(en_first), 64'h1);
        check("restart_beats", 64'(beats), 64'd10);
        run_preload(1'b0, imgs);
        bus.pu_finish_i = 1'b1; step(); bus.pu_finish_i = 1'b0;
        step();
        check("pu_cleared", 64'({obs_pu_en, obs_conv}), 64'b01);
        step(); step(); step();
        check("pu_stays_cleared", 64'({obs_pu_en, obs_conv}), 64'b01);
        bus.conv_finish_i = 1'b1; step(); bus.conv_finish_i = 1'b0;
        count_done(dones);
        check("restart_done", 64'(dones), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // guard against a stuck sequence
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnn_layer_seq.md
Name: cnn_layer_seq

Overview:
- Parametrised CNN layer sequencer that supersedes the fixed single-layer controller.
- Loads a configurable number of filters, each of configurable element count, into one-hot-selected weight buffers over a valid/ready stream.
- Pre-buffers image data, then sequences conv, optional pooling and optional FC stages from their finish handshakes.
- Sits between the AXI input stream and the PU / conv / pooling / FC datapath blocks.

Parameters:
- MAX_FILTERS, 32, number of weight buffers; width of weight_en_o.
- ELEM_W, 6, width of the per-filter element count.
- ELEMS_PER_BEAT, 2, weight elements carried per accepted stream beat.
- IMG_PRELOAD, 68, image beats accepted before conv starts.
- FW, $clog2(MAX_FILTERS+1), width of the filter count.

Ports:
- clk, in, 1, clock.
- nrst, in, 1, asynchronous active-low reset.
- start_i, in, 1, launch pulse; sampled only in IDLE.
- abort_i, in, 1, synchronous abort.
- op_mode_i, in, 3, layer mode: 001 conv, 010 conv+pool, 011 FC only, 110 conv+pool+FC.
- num_filters_i, in, FW, number of filters to load.
- filter_elems_i, in, ELEM_W, elements per filter.
- w_valid_i, in, 1, weight beat valid.
- w_ready_o, out, 1, weight beat ready.
- img_valid_i, in, 1, image beat valid.
- img_ready_o, out, 1, image beat ready.
- pu_finish_i, in, 1, PU stage finished.
- conv_finish_i, in, 1, conv stage finished.
- pool_finish_i, in, 1, pooling stage finished.
- fc_finish_i, in, 1, FC stage finished.
- weight_en_o, out, MAX_FILTERS, one-hot weight buffer write enable.
- pu_en_o, out, 1, PU enable.
- conv_en_o, out, 1, conv enable.
- pool_en_o, out, 1, pooling enable.
- fc_en_o, out, 1, FC enable.
- busy_o, out, 1, block not in IDLE.
- done_o, out, 1, one-cycle layer-complete pulse.
- err_o, out, 1, one-cycle configuration-error pulse.

Behaviour:
- Reset: clk is the clock; reset is nrst, asynchronous, active-low. All outputs 0, state IDLE, all counters 0.
- States: IDLE, LOAD_W, PRELOAD, CONV, POOL, FC, DONE. Outputs are Moore decodes of the state register, except weight_en_o.
- Start: start_i in IDLE latches op_mode_i, num_filters_i and filter_elems_i. Mid-run changes to these inputs are ignored.
- Start error: if the mode is illegal, err_o pulses the next cycle and the block stays in IDLE. Illegal means any mode other than the four above, or num_filters=0, or num_filters>MAX_FILTERS, or filter_elems=0 in a conv mode.
- Mode dispatch: mode 011 → FC. Other legal modes → LOAD_W.
- LOAD_W:
  - w_ready_o=1; filter index f and element count n start at 0.
  - A beat is accepted when w_valid_i & w_ready_o. Each beat adds min(ELEMS_PER_BEAT, filter_elems−n) to n.
  - weight_en_o = onehot(f) & {MAX_FILTERS{w_valid_i}}, combinational.
  - When n reaches filter_elems: n←0, f←f+1.
  - When f reaches num_filters: next state PRELOAD; w_ready_o drops that same transition.
  - An odd element count wastes the tail slot of the last beat of each filter. That beat still asserts weight_en for f.
- PRELOAD: img_ready_o=1, pu_en_o=1. Counts accepted image beats (img_valid_i & img_ready_o); after IMG_PRELOAD beats → CONV.
- CONV:
  - img_ready_o=1, conv_en_o=1.
  - pu_en_o=1 until pu_finish_i is seen once; it is sticky-cleared for the rest of the layer.
  - On conv_finish_i: mode 001 → DONE, otherwise → POOL.
- POOL: pool_en_o=1. On pool_finish_i: mode 110 → FC, otherwise → DONE.
- FC: fc_en_o=1. On fc_finish_i → DONE.
- DONE: done_o=1 for exactly one cycle; all counters cleared; → IDLE.
- busy_o = (state != IDLE).
- Abort: abort_i in any state → IDLE next cycle; counters and all enables cleared. abort_i together with start_i in IDLE means abort wins: no start, no err_o.
- Simultaneous finishes: pu_finish_i and conv_finish_i in the same cycle are both honoured. Finish inputs arriving in a non-matching state are ignored.
- start_i while busy is ignored.
- Counter widths: f is FW bits and never exceeds num_filters. n is ELEM_W+1 bits, so there is no wrap. The preload counter is $clog2(IMG_PRELOAD+1) bits.
- Reset mid-operation returns everything to reset values immediately (asynchronous).

Test Plan:
- Conv load: mode 001, 2 filters × 9 elems, w_valid always 1 → exactly 10 accepted beats. weight_en[0] for beats 1-5, weight_en[1] for beats 6-10, then PRELOAD. After 68 image beats → CONV. conv_finish → DONE, done_o 1 cycle.
- Backpressure: same config, w_valid toggling 1,0,1,0 → weight_en asserted only on valid cycles. Beat count is still 10.
- Full flow: mode 110 with conv_finish, pool_finish, fc_finish each pulsed → state walks CONV, POOL, FC, DONE. Only one of conv_en / pool_en / fc_en is high per stage.
- FC only: mode 011 → IDLE→FC next cycle, no w_ready_o. fc_finish → done_o.
- Errors: mode 100, or num_filters=0 → err_o pulse, busy_o stays 0. start_i together with abort_i → no err_o, stays IDLE.
- Abort and sticky PU: abort_i mid-LOAD_W after 3 beats → IDLE next cycle, weight_en=0; a restart loads from filter 0. In CONV, pu_finish drops pu_en_o permanently while conv_en_o stays 1.
